// File: rtl/cam_fifo_unpacker.sv
// -----------------------------------------------------------------------------
// cam_fifo_unpacker
//
// Read side of the camera pixel FIFO. The capture block writes 17-bit words:
// {1'b0, RGB565} per pixel and 17'h10000 as a frame-start marker. This block
// pops those words, locks onto frame boundaries and emits a framed pixel
// stream (AXI-Stream style) with start-of-frame (tuser) and end-of-line
// (tlast) flags.
//
// Ports:
//   clk            processing clock, also the FIFO read clock
//   rst_n          synchronous, active-low reset
//   fifo_empty     FIFO empty flag
//   fifo_dout      FIFO head word (first-word-fall-through)
//   fifo_rd_en     pop the head word this cycle (combinational)
//   m_tdata        output pixel, RGB565
//   m_tvalid       output beat valid
//   m_tready       downstream accept
//   m_tuser        first pixel of frame
//   m_tlast        last pixel of line
//   frame_count    completed frames, wraps
//   dropped_pixels pixels discarded outside a frame, saturates
//   err_short      one-cycle pulse when a marker truncates a frame
// -----------------------------------------------------------------------------
module cam_fifo_unpacker #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fifo_empty,
  input  logic [16:0]      fifo_dout,
  output logic             fifo_rd_en,
  output logic [15:0]      m_tdata,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic             m_tuser,
  output logic             m_tlast,
  output logic [CNT_W-1:0] frame_count,
  output logic [CNT_W-1:0] dropped_pixels,
  output logic             err_short
);

  // Guard against a degenerate 1-pixel dimension giving a zero-width counter.
  localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

  typedef enum logic {
    WAIT_SOF = 1'b0,
    ACTIVE   = 1'b1
  } state_t;

  state_t           state_reg, state_next;
  logic [XW-1:0]    x_reg, x_next;
  logic [YW-1:0]    y_reg, y_next;
  logic [15:0]      tdata_reg, tdata_next;
  logic             tvalid_reg, tvalid_next;
  logic             tuser_reg, tuser_next;
  logic             tlast_reg, tlast_next;
  logic [CNT_W-1:0] frame_reg, frame_next;
  logic [CNT_W-1:0] dropped_reg, dropped_next;
  logic             err_reg, err_next;

  logic head_is_marker;
  logic out_can_load;
  logic pop_marker;
  logic pop_pixel;

  // Pop decision. Markers are always consumable, pixels are discarded freely
  // while hunting for a frame start, and in-frame pixels need a free output
  // register. Gated by rst_n so nothing is popped while held in reset.
  always_comb begin
    head_is_marker = fifo_dout[16];
    out_can_load   = !tvalid_reg || m_tready;
    fifo_rd_en     = 1'b0;
    if (rst_n && !fifo_empty) begin
      if (head_is_marker || (state_reg == WAIT_SOF) ||
          ((state_reg == ACTIVE) && out_can_load)) begin
        fifo_rd_en = 1'b1;
      end
    end
    pop_marker = fifo_rd_en && head_is_marker;
    pop_pixel  = fifo_rd_en && !head_is_marker;
  end

  // Next-state and datapath.
  always_comb begin
    state_next   = state_reg;
    x_next       = x_reg;
    y_next       = y_reg;
    frame_next   = frame_reg;
    dropped_next = dropped_reg;
    err_next     = 1'b0;
    // A held beat stays valid until accepted; otherwise valid drops unless a
    // new pixel loads below.
    tvalid_next  = tvalid_reg && !m_tready;
    tdata_next   = tdata_reg;
    tuser_next   = tuser_reg;
    tlast_next   = tlast_reg;

    case (state_reg)
      WAIT_SOF: begin
        if (pop_marker) begin
          x_next     = '0;
          y_next     = '0;
          state_next = ACTIVE;
        end else if (pop_pixel && (dropped_reg != {CNT_W{1'b1}})) begin
          dropped_next = dropped_reg + 1'b1;
        end
      end

      ACTIVE: begin
        if (pop_marker) begin
          // A marker at (0,0) is a duplicate and harmless; anywhere else the
          // frame was cut short, so restart it. The held beat is untouched.
          if ((x_reg != '0) || (y_reg != '0)) begin
            err_next = 1'b1;
            x_next   = '0;
            y_next   = '0;
          end
        end else if (pop_pixel) begin
          tvalid_next = 1'b1;
          tdata_next  = fifo_dout[15:0];
          tuser_next  = (x_reg == '0) && (y_reg == '0);
          tlast_next  = (x_reg == X_LAST);
          if (x_reg == X_LAST) begin
            x_next = '0;
            if (y_reg == Y_LAST) begin
              y_next     = '0;
              frame_next = frame_reg + 1'b1;
              state_next = WAIT_SOF;
            end else begin
              y_next = y_reg + 1'b1;
            end
          end else begin
            x_next = x_reg + 1'b1;
          end
        end
      end

      default: state_next = WAIT_SOF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= WAIT_SOF;
      x_reg       <= '0;
      y_reg       <= '0;
      tdata_reg   <= '0;
      tvalid_reg  <= 1'b0;
      tuser_reg   <= 1'b0;
      tlast_reg   <= 1'b0;
      frame_reg   <= '0;
      dropped_reg <= '0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      x_reg       <= x_next;
      y_reg       <= y_next;
      tdata_reg   <= tdata_next;
      tvalid_reg  <= tvalid_next;
      tuser_reg   <= tuser_next;
      tlast_reg   <= tlast_next;
      frame_reg   <= frame_next;
      dropped_reg <= dropped_next;
      err_reg     <= err_next;
    end
  end

  assign m_tdata        = tdata_reg;
  assign m_tvalid       = tvalid_reg;
  assign m_tuser        = tuser_reg;
  assign m_tlast        = tlast_reg;
  assign frame_count    = frame_reg;
  assign dropped_pixels = dropped_reg;
  assign err_short      = err_reg;

endmodule
